// File: rtl/fpu_ret_collect.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_ret_collect
//  Description : Collects per-lane FP retire words (u1/u3/u5), queues them in
//                lane order in a first-word-fall-through FIFO and drains one
//                per cycle over valid/ready. Tracks sticky IEEE exception
//                flags, a sticky overflow error and an issue stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_ret_collect #(
   parameter int DEPTH = 8,
   parameter int RET_W = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RET_W-1:0] u1_ret,
   input  logic             u1_ret_en,
   input  logic [RET_W-1:0] u3_ret,
   input  logic             u3_ret_en,
   input  logic [RET_W-1:0] u5_ret,
   input  logic             u5_ret_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RET_W-1:0] out_ret,
   output logic [1:0]       out_lane,
   output logic             stall_o,
   output logic             ovf_err,
   output logic [5:0]       flags_sticky,
   input  logic             flags_clr
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int ENT_W = RET_W + 2;

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic [5:0]       flags_q, flags_d;

   logic [RET_W-1:0] w_ret [3];
   logic [2:0]       w_en;
   logic             w_pop;
   logic [CW-1:0]    w_cap;
   logic [CW-1:0]    w_n;
   logic [2:0]       w_acc;
   logic [1:0]       w_slot [3];
   logic [5:0]       w_flags;
   logic             w_drop;

   assign w_ret[0] = u1_ret;
   assign w_ret[1] = u3_ret;
   assign w_ret[2] = u5_ret;
   assign w_en     = {u5_ret_en, u3_ret_en, u1_ret_en};

   // A pop only happens when the head is valid; it frees a slot this cycle.
   assign w_pop = (count_q != '0) && out_ready;
   assign w_cap = CW'(DEPTH) - count_q + CW'(w_pop);

   // Compact enabled lanes in u1,u3,u5 order; lanes beyond capacity are dropped.
   always_comb begin
      w_n     = '0;
      w_acc   = '0;
      w_flags = '0;
      w_drop  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         w_slot[k] = '0;
         if (w_en[k]) begin
            if (w_n < w_cap) begin
               w_acc[k]  = 1'b1;
               w_slot[k] = w_n[1:0];
               w_flags   = w_flags | w_ret[k][5:0];
               w_n       = w_n + CW'(1);
            end else begin
               w_drop = 1'b1;
            end
         end
      end
   end

   // Next-state for pointers, occupancy and sticky status (flag set wins over clear).
   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(w_pop);
      wr_ptr_d = wr_ptr_q + AW'(w_n);
      count_d  = count_q + w_n - CW'(w_pop);
      ovf_d    = ovf_q | w_drop;
      flags_d  = (flags_clr ? 6'h00 : flags_q) | w_flags;
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         flags_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         flags_q  <= flags_d;
      end
   end

   // Storage: each accepted lane writes {lane, ret} into its compacted slot.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            if (w_acc[k]) begin
               mem_q[wr_ptr_q + AW'(w_slot[k])] <= {2'(k), w_ret[k]};
            end
         end
      end
   end

   // Outputs come from registered state only; no input-to-output bypass.
   always_comb begin
      out_valid    = (count_q != '0);
      out_ret      = mem_q[rd_ptr_q][RET_W-1:0];
      out_lane     = mem_q[rd_ptr_q][ENT_W-1:RET_W];
      stall_o      = (CW'(DEPTH) - count_q) < CW'(3);
      ovf_err      = ovf_q;
      flags_sticky = flags_q;
   end

endmodule
`default_nettype wire
